// File: rtl/alu_op_sequencer.sv
// Key-combination front end for an ALU: synchronizes buttons, captures a combo over a
// fixed window, decodes it to an opcode, issues one start pulse and waits for the result.
module alu_op_sequencer #(
  parameter int WIDTH   = 4,
  parameter int WINDOW  = 1000,
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       key,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic [3:0]       alu_opcode,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic             alu_start,
  input  logic             alu_done,
  input  logic [WIDTH-1:0] alu_result,
  output logic [WIDTH-1:0] result,
  output logic             result_valid,
  output logic             op_err,
  output logic             busy
);

  localparam int WIN_W = $clog2(WINDOW + 1);
  localparam int TMO_W = $clog2(TIMEOUT + 1);
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CAPTURE, S_ISSUE, S_WAIT, S_DONE, S_RELEASE
  } state_t;

  state_t           state;
  logic [3:0]       key_p0;
  logic [3:0]       ks;
  logic [3:0]       acc;
  logic [3:0]       acc_next;
  logic [4:0]       dec;
  logic [WIN_W-1:0] win_cnt;
  logic [TMO_W-1:0] tmo_cnt;
  logic             rel_seen;

  // {valid, opcode}; any combination not listed is rejected
  function automatic logic [4:0] decode(input logic [3:0] combo);
    case (combo)
      4'b0001: return {1'b1, 4'b0000};
      4'b0010: return {1'b1, 4'b0001};
      4'b0100: return {1'b1, 4'b0010};
      4'b1000: return {1'b1, 4'b0011};
      4'b0101: return {1'b1, 4'b0100};
      4'b0011: return {1'b1, 4'b0101};
      4'b0110: return {1'b1, 4'b0110};
      4'b1100: return {1'b1, 4'b0111};
      4'b0111: return {1'b1, 4'b1000};
      4'b1110: return {1'b1, 4'b1001};
      default: return 5'b0_0000;
    endcase
  endfunction

  function automatic logic [WIN_W-1:0] sat_win(input logic [WIN_W-1:0] c);
    return (c == {WIN_W{1'b1}}) ? c : c + 1'b1;
  endfunction

  function automatic logic [TMO_W-1:0] sat_tmo(input logic [TMO_W-1:0] c);
    return (c == {TMO_W{1'b1}}) ? c : c + 1'b1;
  endfunction

  // The final capture cycle's keys still count toward the decoded combo
  assign acc_next = acc | ks;
  assign dec      = decode(acc_next);
  assign busy     = (state != S_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      key_p0       <= '0;
      ks           <= '0;
      acc          <= '0;
      win_cnt      <= '0;
      tmo_cnt      <= '0;
      rel_seen     <= 1'b0;
      alu_opcode   <= '0;
      alu_a        <= '0;
      alu_b        <= '0;
      alu_start    <= 1'b0;
      result       <= '0;
      result_valid <= 1'b0;
      op_err       <= 1'b0;
    end else begin
      key_p0    <= key;
      ks        <= key_p0;
      alu_start <= 1'b0;
      case (state)
        S_IDLE: begin
          if (ks != 4'b0000) begin
            acc     <= ks;
            win_cnt <= '0;
            state   <= S_CAPTURE;
          end
        end
        S_CAPTURE: begin
          acc <= acc_next;
          if (win_cnt == WIN_LAST) begin
            rel_seen <= 1'b0;
            if (dec[4]) begin
              alu_opcode   <= dec[3:0];
              alu_a        <= a_in;
              alu_b        <= b_in;
              alu_start    <= 1'b1;
              op_err       <= 1'b0;
              result_valid <= 1'b0;
              state        <= S_ISSUE;
            end else begin
              op_err <= 1'b1;
              state  <= S_RELEASE;
            end
          end else begin
            win_cnt <= sat_win(win_cnt);
          end
        end
        S_ISSUE: begin
          tmo_cnt <= '0;
          state   <= S_WAIT;
        end
        S_WAIT: begin
          // Completion takes priority over a timeout expiring on the same edge
          if (alu_done) begin
            result       <= alu_result;
            result_valid <= 1'b1;
            state        <= S_DONE;
          end else if (tmo_cnt == TMO_LAST) begin
            op_err   <= 1'b1;
            rel_seen <= 1'b0;
            state    <= S_RELEASE;
          end else begin
            tmo_cnt <= sat_tmo(tmo_cnt);
          end
        end
        S_DONE: begin
          rel_seen <= 1'b0;
          state    <= S_RELEASE;
        end
        S_RELEASE: begin
          if (ks != 4'b0000) begin
            rel_seen <= 1'b0;
          end else if (rel_seen) begin
            state <= S_IDLE;
          end else begin
            rel_seen <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with a short window and timeout.
module tb_alu_op_sequencer;

  localparam int WIDTH   = 4;
  localparam int WINDOW  = 8;
  localparam int TIMEOUT = 10;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [3:0]       key;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic [3:0]       alu_opcode;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic             alu_start;
  logic             alu_done;
  logic [WIDTH-1:0] alu_result;
  logic [WIDTH-1:0] result;
  logic             result_valid;
  logic             op_err;
  logic             busy;

  int n_checks = 0;
  int n_errors = 0;
  int starts   = 0;

  alu_op_sequencer #(.WIDTH(WIDTH), .WINDOW(WINDOW), .TIMEOUT(TIMEOUT)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .key          (key),
    .a_in         (a_in),
    .b_in         (b_in),
    .alu_opcode   (alu_opcode),
    .alu_a        (alu_a),
    .alu_b        (alu_b),
    .alu_start    (alu_start),
    .alu_done     (alu_done),
    .alu_result   (alu_result),
    .result       (result),
    .result_valid (result_valid),
    .op_err       (op_err),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  // Every high cycle of alu_start is counted, so a stretched pulse shows up
  always @(negedge clk) if (alu_start === 1'b1) starts++;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_start(input int max, output int cyc);
    cyc = 0;
    while (alu_start !== 1'b1 && cyc < max) begin
      step(1);
      cyc++;
    end
    check("start_seen", 32'(alu_start), 1);
  endtask

  // Called in the ISSUE cycle: alu_done is sampled two edges after alu_start rose
  task automatic respond(input logic [3:0] r);
    step(1);
    alu_done   = 1'b1;
    alu_result = r;
    step(1);
    alu_done   = 1'b0;
  endtask

  task automatic release_keys(input string tag);
    key = 4'b0000;
    step(5);
    check(tag, 32'(busy), 0);
  endtask

  task automatic check_reset_values();
    check("rst_opcode", 32'(alu_opcode), 0);
    check("rst_a", 32'(alu_a), 0);
    check("rst_b", 32'(alu_b), 0);
    check("rst_start", 32'(alu_start), 0);
    check("rst_result", 32'(result), 0);
    check("rst_valid", 32'(result_valid), 0);
    check("rst_err", 32'(op_err), 0);
    check("rst_busy", 32'(busy), 0);
  endtask

  initial begin
    int cyc;
    int s0;
    rst_n      = 1'b0;
    key        = 4'b0000;
    a_in       = '0;
    b_in       = '0;
    alu_done   = 1'b0;
    alu_result = '0;
    #1;
    check_reset_values();
    step(3);
    rst_n = 1'b1;
    step(2);
    check("idle_busy", 32'(busy), 0);

    // add: 3 + 5, key held WINDOW+10 cycles
    s0   = starts;
    a_in = 4'd3;
    b_in = 4'd5;
    key  = 4'b0001;
    wait_start(40, cyc);
    check("add_latency", 32'(cyc), WINDOW + 3);
    check("add_opcode", 32'(alu_opcode), 4'b0000);
    check("add_a", 32'(alu_a), 3);
    check("add_b", 32'(alu_b), 5);
    respond(4'd8);
    check("add_result", 32'(result), 8);
    check("add_valid", 32'(result_valid), 1);
    check("add_err", 32'(op_err), 0);
    step(5);
    check("add_one_start", 32'(starts - s0), 1);
    check("add_busy_held", 32'(busy), 1);
    check("add_opcode_held", 32'(alu_opcode), 4'b0000);
    release_keys("add_idle");

    // 0001 then 0100 three cycles later -> mod
    s0   = starts;
    a_in = 4'd7;
    b_in = 4'd2;
    key  = 4'b0001;
    step(3);
    key  = 4'b0101;
    wait_start(40, cyc);
    check("mod_opcode", 32'(alu_opcode), 4'b0100);
    check("mod_a", 32'(alu_a), 7);
    respond(4'd1);
    check("mod_result", 32'(result), 1);
    check("mod_valid", 32'(result_valid), 1);
    release_keys("mod_idle");

    // invalid combo 1001
    s0  = starts;
    key = 4'b1001;
    step(WINDOW + 5);
    check("inv_err", 32'(op_err), 1);
    check("inv_no_start", 32'(starts - s0), 0);
    check("inv_result", 32'(result), 1);
    check("inv_valid", 32'(result_valid), 1);
    check("inv_opcode", 32'(alu_opcode), 4'b0100);
    check("inv_busy", 32'(busy), 1);
    release_keys("inv_idle");
    check("inv_err_sticky", 32'(op_err), 1);

    // sub with no alu_done -> timeout
    a_in = 4'd9;
    b_in = 4'd4;
    key  = 4'b0010;
    wait_start(40, cyc);
    check("tmo_opcode", 32'(alu_opcode), 4'b0001);
    check("tmo_err_cleared", 32'(op_err), 0);
    check("tmo_valid_cleared", 32'(result_valid), 0);
    step(1);
    step(TIMEOUT - 1);
    check("tmo_err_early", 32'(op_err), 0);
    step(1);
    check("tmo_err", 32'(op_err), 1);
    check("tmo_valid", 32'(result_valid), 0);
    check("tmo_result", 32'(result), 1);
    release_keys("tmo_idle");

    // alu_done on the very edge the timeout expires
    a_in = 4'd8;
    b_in = 4'd2;
    key  = 4'b1000;
    wait_start(40, cyc);
    check("div_opcode", 32'(alu_opcode), 4'b0011);
    step(1);
    step(TIMEOUT - 1);
    alu_done   = 1'b1;
    alu_result = 4'd4;
    step(1);
    alu_done   = 1'b0;
    check("edge_valid", 32'(result_valid), 1);
    check("edge_result", 32'(result), 4);
    check("edge_err", 32'(op_err), 0);
    release_keys("edge_idle");

    // long hold -> single op, then re-press -> second op
    s0   = starts;
    a_in = 4'd6;
    b_in = 4'd3;
    key  = 4'b0011;
    wait_start(40, cyc);
    check("and_opcode", 32'(alu_opcode), 4'b0101);
    respond(4'd2);
    check("and_result", 32'(result), 2);
    step(5 * WINDOW - (WINDOW + 5));
    check("hold_one_start", 32'(starts - s0), 1);
    release_keys("hold_idle");
    key = 4'b0110;
    wait_start(40, cyc);
    check("or_opcode", 32'(alu_opcode), 4'b0110);
    respond(4'd7);
    check("or_result", 32'(result), 7);
    check("repress_starts", 32'(starts - s0), 2);
    release_keys("or_idle");

    // stray alu_done in IDLE
    alu_done   = 1'b1;
    alu_result = 4'd15;
    step(1);
    alu_done   = 1'b0;
    step(1);
    check("stray_result", 32'(result), 7);
    check("stray_valid", 32'(result_valid), 1);
    check("stray_busy", 32'(busy), 0);

    // reset in WAIT, late alu_done, key still held
    a_in = 4'd1;
    b_in = 4'd1;
    key  = 4'b0001;
    wait_start(40, cyc);
    step(3);
    rst_n = 1'b0;
    #1;
    check_reset_values();
    step(2);
    s0         = starts;
    rst_n      = 1'b1;
    alu_done   = 1'b1;
    alu_result = 4'd9;
    step(1);
    alu_done   = 1'b0;
    check("late_done_result", 32'(result), 0);
    check("late_done_valid", 32'(result_valid), 0);
    wait_start(40, cyc);
    check("post_rst_latency", 32'(cyc), WINDOW + 2);
    check("post_rst_no_dup", 32'(starts - s0), 0);
    respond(4'd2);
    check("post_rst_result", 32'(result), 2);
    check("post_rst_starts", 32'(starts - s0), 1);
    release_keys("post_rst_idle");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
